// File: rtl/trace_buffer.sv
// Writeback trace buffer: captures retired register writes into a circular buffer.
// A trigger unit and a post-trigger window control capture; a valid/ready port reads the buffer out.
module trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int PC_W       = 16,
  parameter int RA_W       = 4,
  parameter int DEPTH_LOG2 = 4,
  parameter int CYC_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_i,
  input  logic [RA_W-1:0]       dest_reg_addr_i,
  input  logic [DATA_W-1:0]     wb_data_i,
  input  logic [PC_W-1:0]       pc_i,
  input  logic                  arm_i,
  input  logic [1:0]            trig_mode_i,
  input  logic [PC_W-1:0]       trig_pc_i,
  input  logic [RA_W-1:0]       trig_reg_i,
  input  logic [DEPTH_LOG2:0]   post_cnt_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic [CYC_W-1:0]      rd_cyc_o,
  output logic [PC_W-1:0]       rd_pc_o,
  output logic [RA_W-1:0]       rd_reg_o,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  overflow_o,
  output logic [1:0]            state_o,
  output logic [CYC_W-1:0]      cycle_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  typedef struct packed {
    logic [CYC_W-1:0]  cyc;
    logic [PC_W-1:0]   pc;
    logic [RA_W-1:0]   dest;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  state_e           state_q, state_d;
  cnt_t             count_q, count_d;
  cnt_t             remaining_q, remaining_d;
  cnt_t             post_cnt_q, post_cnt_d;
  ptr_t             wr_ptr_q, wr_ptr_d;
  logic             overflow_q, overflow_d;
  logic [CYC_W-1:0] cycle_q, cycle_d;
  logic [1:0]       trig_mode_q, trig_mode_d;
  logic [PC_W-1:0]  trig_pc_q, trig_pc_d;
  logic [RA_W-1:0]  trig_reg_q, trig_reg_d;

  entry_t mem [DEPTH];
  entry_t rd_entry;
  ptr_t   rd_ptr;
  logic   capture, trig_hit, full, rd_valid, pop;

  // Oldest entry sits count places behind the write pointer; wraps naturally.
  assign rd_ptr   = wr_ptr_q - count_q[DEPTH_LOG2-1:0];
  assign rd_entry = mem[rd_ptr];
  assign full     = (count_q == DEPTH_CNT);
  assign rd_valid = (state_q == S_DONE) && (count_q != '0);
  assign pop      = rd_valid && rd_ready_i;
  assign capture  = wb_en_i && ((state_q == S_ARMED) || (state_q == S_POST));

  always_comb begin
    unique case (trig_mode_q)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = (pc_i == trig_pc_q);
      2'd2:    trig_hit = (dest_reg_addr_i == trig_reg_q);
      default: trig_hit = 1'b0;
    endcase
  end

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    post_cnt_d  = post_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    overflow_d  = overflow_q;
    cycle_d     = cycle_q + CYC_W'(1);
    trig_mode_d = trig_mode_q;
    trig_pc_d   = trig_pc_q;
    trig_reg_d  = trig_reg_q;

    unique case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d     = S_ARMED;
          count_d     = '0;
          wr_ptr_d    = '0;
          overflow_d  = 1'b0;
          trig_mode_d = trig_mode_i;
          trig_pc_d   = trig_pc_i;
          trig_reg_d  = trig_reg_i;
          post_cnt_d  = post_cnt_i;
        end
      end
      S_ARMED: begin
        if (!arm_i) begin
          state_d = S_DONE;
        end else if (capture && trig_hit) begin
          remaining_d = post_cnt_q;
          state_d     = (post_cnt_q == '0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (capture) remaining_d = remaining_q - cnt_t'(1);
        if (!arm_i || (capture && remaining_q == cnt_t'(1))) state_d = S_DONE;
      end
      S_DONE: begin
        if (count_q == '0 && !arm_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (full) overflow_d = 1'b1;
      else      count_d    = count_q + cnt_t'(1);
    end
    if (pop) count_d = count_q - cnt_t'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      cycle_q     <= '0;
      trig_mode_q <= '0;
      trig_pc_q   <= '0;
      trig_reg_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      post_cnt_q  <= post_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      overflow_q  <= overflow_d;
      cycle_q     <= cycle_d;
      trig_mode_q <= trig_mode_d;
      trig_pc_q   <= trig_pc_d;
      trig_reg_q  <= trig_reg_d;
    end
  end

  // NOTE: the storage array has no reset; readout is gated by count, so stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr_q] <= '{cyc: cycle_q, pc: pc_i, dest: dest_reg_addr_i, data: wb_data_i};
  end

  assign rd_valid_o = rd_valid;
  assign rd_cyc_o   = rd_valid ? rd_entry.cyc  : '0;
  assign rd_pc_o    = rd_valid ? rd_entry.pc   : '0;
  assign rd_reg_o   = rd_valid ? rd_entry.dest : '0;
  assign rd_data_o  = rd_valid ? rd_entry.data : '0;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign state_o    = state_q;
  assign cycle_o    = cycle_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: a queue scoreboard holds expected entries as writes are driven
// and is popped as the buffer is read out.
module tb_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en_i = 1'b0;
  logic [3:0]  dest_reg_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [15:0] pc_i = '0;
  logic        arm_i = 1'b0;
  logic [1:0]  trig_mode_i = '0;
  logic [15:0] trig_pc_i = '0;
  logic [3:0]  trig_reg_i = '0;
  logic [4:0]  post_cnt_i = '0;
  logic        rd_ready_i = 1'b0;
  logic        rd_valid_o;
  logic [31:0] rd_cyc_o;
  logic [15:0] rd_pc_o;
  logic [3:0]  rd_reg_o;
  logic [31:0] rd_data_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [1:0]  state_o;
  logic [31:0] cycle_o;

  typedef struct {
    logic [31:0] cyc;
    logic [15:0] pc;
    logic [3:0]  rg;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] tb_cyc;
  int          total = 0;
  int          bad   = 0;

  trace_buffer dut (
    .clk(clk), .rst(rst), .wb_en_i(wb_en_i), .dest_reg_addr_i(dest_reg_addr_i),
    .wb_data_i(wb_data_i), .pc_i(pc_i), .arm_i(arm_i), .trig_mode_i(trig_mode_i),
    .trig_pc_i(trig_pc_i), .trig_reg_i(trig_reg_i), .post_cnt_i(post_cnt_i),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_cyc_o(rd_cyc_o),
    .rd_pc_o(rd_pc_o), .rd_reg_o(rd_reg_o), .rd_data_o(rd_data_o), .count_o(count_o),
    .overflow_o(overflow_o), .state_o(state_o), .cycle_o(cycle_o)
  );

  always #5 clk = ~clk;

  // Reference cycle count: value visible between edges equals the timestamp of the next capture.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cyc <= '0;
    else      tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic arm(input logic [1:0] mode, input logic [15:0] tpc, input logic [3:0] treg,
                     input logic [4:0] post);
    trig_mode_i = mode; trig_pc_i = tpc; trig_reg_i = treg; post_cnt_i = post;
    arm_i = 1'b1;
    tick();
    trig_mode_i = 2'd3; trig_pc_i = 16'hFFFF; trig_reg_i = 4'hF; post_cnt_i = '0;
  endtask

  task automatic wb(input logic [15:0] pc, input logic [3:0] rg, input logic [31:0] data,
                    input bit cap);
    ent_t e;
    wb_en_i = 1'b1; pc_i = pc; dest_reg_addr_i = rg; wb_data_i = data;
    if (cap) begin
      e.cyc = tb_cyc; e.pc = pc; e.rg = rg; e.data = data;
      if (exp_q.size() == 16) void'(exp_q.pop_front());
      exp_q.push_back(e);
    end
    tick();
    wb_en_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    ent_t e;
    int   guard = 0;
    rd_ready_i = 1'b1;
    while (exp_q.size() > 0 && guard < 40) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 64'(rd_valid_o), 64'd1);
      check({tag, "_count"}, 64'(count_o), 64'(exp_q.size() + 1));
      check({tag, "_cyc"},   64'(rd_cyc_o),  64'(e.cyc));
      check({tag, "_pc"},    64'(rd_pc_o),   64'(e.pc));
      check({tag, "_reg"},   64'(rd_reg_o),  64'(e.rg));
      check({tag, "_data"},  64'(rd_data_o), 64'(e.data));
      tick();
      guard++;
    end
    rd_ready_i = 1'b0;
    check({tag, "_empty_valid"}, 64'(rd_valid_o), 64'd0);
    check({tag, "_empty_count"}, 64'(count_o), 64'd0);
    tick();
    check({tag, "_idle"}, 64'(state_o), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_ovf",   64'(overflow_o), 64'd0);
    check("rst_valid", 64'(rd_valid_o), 64'd0);
    check("rst_data",  64'(rd_data_o), 64'd0);
    check("rst_cycle", 64'(cycle_o), 64'd0);

    // Mode 0, post_cnt 2: writes at cycles 20..22.
    arm(2'd0, 16'h0, 4'h0, 5'd2);
    check("m0_armed", 64'(state_o), 64'd1);
    for (int i = 0; i < 50 && tb_cyc != 32'd20; i++) tick();
    check("m0_cyc20", 64'(cycle_o), 64'd20);
    wb(16'h0100, 4'd1, 32'h11, 1'b1);
    check("m0_post", 64'(state_o), 64'd2);
    wb(16'h0104, 4'd2, 32'h22, 1'b1);
    wb(16'h0108, 4'd3, 32'h33, 1'b1);
    check("m0_done",  64'(state_o), 64'd3);
    check("m0_count", 64'(count_o), 64'd3);
    check("m0_ts0",   64'(rd_cyc_o), 64'd20);
    arm_i = 1'b0;
    drain("m0");

    // Mode 1: PC match at 0x0010, 20 writes wrap a 16-entry buffer.
    arm(2'd1, 16'h0010, 4'h0, 5'd3);
    for (int i = 0; i < 20; i++) wb(16'(i), 4'(i), 32'hA000 + 32'(i), 1'b1);
    check("m1_done",   64'(state_o), 64'd3);
    check("m1_count",  64'(count_o), 64'd16);
    check("m1_ovf",    64'(overflow_o), 64'd1);
    check("m1_firstpc", 64'(rd_pc_o), 64'h0004);
    arm_i = 1'b0;
    drain("m1");

    // Mode 2: register match on r5, post_cnt 0.
    arm(2'd2, 16'h0, 4'd5, 5'd0);
    wb(16'h0200, 4'd1, 32'hB1, 1'b1);
    wb(16'h0204, 4'd2, 32'hB2, 1'b1);
    check("m2_armed", 64'(state_o), 64'd1);
    wb(16'h0208, 4'd5, 32'hB5, 1'b1);
    check("m2_done",  64'(state_o), 64'd3);
    check("m2_count", 64'(count_o), 64'd3);
    check("m2_ovf",   64'(overflow_o), 64'd0);
    wb(16'h020C, 4'd6, 32'hB6, 1'b0);
    check("m2_nocap", 64'(count_o), 64'd3);
    arm_i = 1'b0;
    drain("m2");

    // Mode 3: never triggers; abort by dropping arm, then stall the reader.
    arm(2'd3, 16'h0, 4'h0, 5'd1);
    for (int i = 0; i < 4; i++) wb(16'h0300 + 16'(i), 4'(i + 8), 32'hC0 + 32'(i), 1'b1);
    check("m3_armed", 64'(state_o), 64'd1);
    arm_i = 1'b0;
    tick();
    check("m3_done",  64'(state_o), 64'd3);
    check("m3_count", 64'(count_o), 64'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("m3_hold_valid", 64'(rd_valid_o), 64'd1);
      check("m3_hold_data",  64'(rd_data_o), 64'(exp_q[0].data));
      check("m3_hold_count", 64'(count_o), 64'd4);
    end
    drain("m3");

    // Abort during POST with a write on the same edge.
    arm(2'd0, 16'h0, 4'h0, 5'd5);
    wb(16'h0400, 4'd1, 32'hD1, 1'b1);
    wb(16'h0404, 4'd2, 32'hD2, 1'b1);
    check("ab_post", 64'(state_o), 64'd2);
    arm_i = 1'b0;
    wb(16'h0408, 4'd3, 32'hD3, 1'b1);
    check("ab_done",  64'(state_o), 64'd3);
    check("ab_count", 64'(count_o), 64'd3);
    drain("ab");

    // Reset while in POST holding 5 entries.
    arm(2'd0, 16'h0, 4'h0, 5'd10);
    for (int i = 0; i < 5; i++) wb(16'h0500 + 16'(i), 4'(i), 32'hE0 + 32'(i), 1'b1);
    check("rp_post",  64'(state_o), 64'd2);
    check("rp_count", 64'(count_o), 64'd5);
    rst = 1'b0;
    arm_i = 1'b0;
    exp_q.delete();
    tick();
    check("rp_state", 64'(state_o), 64'd0);
    check("rp_cnt0",  64'(count_o), 64'd0);
    check("rp_ovf",   64'(overflow_o), 64'd0);
    check("rp_valid", 64'(rd_valid_o), 64'd0);
    check("rp_cycle", 64'(cycle_o), 64'd0);
    rst = 1'b1;
    tick();
    check("rp_cycle_run", 64'(cycle_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
